// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester and transmitter signals shared by the UART TX arbiter
// master: client/transmitter side, drives req_valid, req_data, tx_busy
// slave:  arbiter side, drives req_ready, tx_start, tx_data, active_id,
//         ctrl_busy, frame_done, err_timeout
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W = 8
);
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0] req_ready;
    logic tx_start;
    logic [DATA_W-1:0] tx_data;
    logic tx_busy;
    logic [$clog2(NUM_REQ)-1:0] active_id;
    logic ctrl_busy;
    logic frame_done;
    logic err_timeout;
    modport master (
        output req_valid, req_data, tx_busy,
        input  req_ready, tx_start, tx_data, active_id, ctrl_busy, frame_done, err_timeout
    );
    modport slave (
        input  req_valid, req_data, tx_busy,
        output req_ready, tx_start, tx_data, active_id, ctrl_busy, frame_done, err_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART byte transmitter among NUM_REQ requesters
// clk, rst_n : clock, synchronous active-low reset
// bus (slave): req_valid/req_data/req_ready per-requester byte handshake,
//              tx_start/tx_data/tx_busy transmitter control,
//              active_id/ctrl_busy/frame_done/err_timeout status
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W = 8,
    parameter int ACK_TIMEOUT = 8
) (
    input logic clk,
    input logic rst_n,
    uart_tx_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;
    state_t state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] win;
    logic [7:0] cnt;
    logic grant;
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        return IW'(s >= NUM_REQ ? s - NUM_REQ : s);
    endfunction
    // scan from the farthest offset down so the nearest valid requester after rr_ptr wins
    always_comb begin
        win = rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (bus.req_valid[wrap_add(rr_ptr, k)]) win = wrap_add(rr_ptr, k);
    end
    assign grant = state == IDLE && !bus.tx_busy && |bus.req_valid;
    assign bus.req_ready = grant ? NUM_REQ'(1) << win : '0;
    assign bus.ctrl_busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            rr_ptr <= '0;
            cnt <= '0;
            bus.tx_start <= 1'b0;
            bus.tx_data <= '0;
            bus.active_id <= '0;
            bus.frame_done <= 1'b0;
            bus.err_timeout <= 1'b0;
        end else begin
            bus.tx_start <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.err_timeout <= 1'b0;
            case (state)
                IDLE: if (grant) begin
                    bus.tx_data <= bus.req_data[win*DATA_W +: DATA_W];
                    bus.active_id <= win;
                    rr_ptr <= wrap_add(win, 1);
                    bus.tx_start <= 1'b1;
                    state <= START;
                end
                START: begin
                    cnt <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: if (bus.tx_busy) state <= WAIT_DONE;
                else begin
                    cnt <= cnt + 8'd1;
                    if (cnt + 8'd1 == 8'(ACK_TIMEOUT)) begin
                        bus.err_timeout <= 1'b1;
                        state <= IDLE;
                    end
                end
                WAIT_DONE: if (!bus.tx_busy) begin
                    bus.frame_done <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of uart_tx_arbiter against a transaction-level model
module tb_uart_tx_arbiter;
    localparam int N = 4;
    localparam int W = 8;
    localparam int T = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bif ();
    uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .ACK_TIMEOUT(T)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bif)
    );
    int total = 0;
    int bad = 0;
    int mptr = 0;
    int exp_id = 0;
    logic [W-1:0] exp_data = '0;
    bit pend_done = 0;
    bit pend_to = 0;
    bit scr = 0;
    int ids[$];
    logic [W-1:0] bytes[$];
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    // first valid requester at or after p, modulo N
    function automatic int winner(input int p, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction
    task automatic cycle(input logic [N-1:0] v, input logic b);
        @(negedge clk);
        bif.req_valid = v;
        bif.tx_busy = b;
        #1;
    endtask
    // one cycle with the arbiter expected idle; reports whether a byte is accepted
    task automatic idle_cyc(input logic [N-1:0] v, input logic b, output bit acc);
        int w;
        cycle(v, b);
        chk("frame_done", bif.frame_done, pend_done);
        chk("err_timeout", bif.err_timeout, pend_to);
        pend_done = 0;
        pend_to = 0;
        chk("idle_ctrl_busy", bif.ctrl_busy, 0);
        chk("idle_tx_start", bif.tx_start, 0);
        chk("held_tx_data", bif.tx_data, exp_data);
        chk("held_active_id", bif.active_id, exp_id);
        acc = !b && v != 0;
        w = acc ? winner(mptr, v) : 0;
        chk("req_ready", bif.req_ready, acc ? 32'(1) << w : 0);
        if (acc) begin
            exp_data = bif.req_data[w*W +: W];
            exp_id = w;
            mptr = (w + 1) % N;
        end
    endtask
    // cycles after an accept: tx_busy rises d cycles after tx_start for len cycles; d<=0 never rises
    task automatic frame(input logic [N-1:0] vm, input int d, input int len);
        bit to;
        int e;
        to = d <= 0;
        e = to ? 2 + T : 2 + d + len;
        for (int k = 1; k < e; k++) begin
            cycle(vm, !to && k >= 1 + d && k < 1 + d + len);
            chk("tx_start", bif.tx_start, k == 1);
            chk("frame_done_early", bif.frame_done, 0);
            chk("err_timeout_early", bif.err_timeout, 0);
            chk("ctrl_busy", bif.ctrl_busy, 1);
            chk("ready_in_frame", bif.req_ready, 0);
            chk("tx_data", bif.tx_data, exp_data);
            chk("active_id", bif.active_id, exp_id);
            if (k == 1) begin
                ids.push_back(int'(bif.active_id));
                bytes.push_back(bif.tx_data);
            end
            if (scr) bif.req_data = (N*W)'($urandom);
        end
        pend_done = !to;
        pend_to = to;
    endtask
    task automatic chk_reset();
        chk("rst_tx_start", bif.tx_start, 0);
        chk("rst_tx_data", bif.tx_data, 0);
        chk("rst_active_id", bif.active_id, 0);
        chk("rst_frame_done", bif.frame_done, 0);
        chk("rst_err_timeout", bif.err_timeout, 0);
        chk("rst_ctrl_busy", bif.ctrl_busy, 0);
        chk("rst_req_ready", bif.req_ready, 0);
    endtask
    initial begin
        #1000000;
        $fatal(1, "FAIL watchdog simulation time limit reached");
    end
    initial begin
        bit acc;
        int ord4[5] = '{0, 1, 2, 3, 0};
        int ordf[3] = '{0, 2, 0};
        bif.req_valid = '0;
        bif.req_data = '0;
        bif.tx_busy = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_reset();
        rst_n = 1'b1;
        // all four requesters valid continuously
        bif.req_data = 32'hA3A2A1A0;
        repeat (5) begin
            idle_cyc(4'hF, 1'b0, acc);
            frame(4'hF, 1 + $urandom_range(0, 2), 3 + $urandom_range(0, 5));
        end
        for (int i = 0; i < 5; i++) begin
            chk("rr_order", ids[i], ord4[i]);
            chk("rr_bytes", bytes[i], 8'hA0 + 8'(ord4[i]));
        end
        // single request, busy two cycles after start for twenty cycles
        bif.req_data = {24'h123456, 8'h55};
        idle_cyc(4'h1, 1'b0, acc);
        frame(4'h0, 2, 20);
        // fairness: req0 stays valid, req2 joins during req0's frame
        ids.delete();
        idle_cyc(4'h1, 1'b0, acc);
        frame(4'h5, 2, 4);
        idle_cyc(4'h5, 1'b0, acc);
        frame(4'h5, 1, 3);
        idle_cyc(4'h5, 1'b0, acc);
        frame(4'h5, 3, 2);
        for (int i = 0; i < 3; i++) chk("fair_order", ids[i], ordf[i]);
        // acknowledge timeout, then the next requester is served
        idle_cyc(4'h8, 1'b0, acc);
        frame(4'h0, 0, 0);
        idle_cyc(4'hA, 1'b0, acc);
        frame(4'h0, T, 2);
        // transmitter still draining while idle
        idle_cyc(4'h2, 1'b1, acc);
        idle_cyc(4'h2, 1'b1, acc);
        idle_cyc(4'h2, 1'b1, acc);
        idle_cyc(4'h2, 1'b0, acc);
        frame(4'h0, 1, 1);
        // reset while waiting for the frame to finish
        idle_cyc(4'h4, 1'b0, acc);
        cycle(4'h0, 1'b0);
        chk("mid_tx_start", bif.tx_start, 1);
        cycle(4'h0, 1'b1);
        cycle(4'h0, 1'b1);
        chk("mid_ctrl_busy", bif.ctrl_busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk_reset();
        rst_n = 1'b1;
        mptr = 0;
        exp_data = '0;
        exp_id = 0;
        pend_done = 0;
        pend_to = 0;
        idle_cyc(4'hF, 1'b1, acc);
        idle_cyc(4'hF, 1'b0, acc);
        chk("post_reset_id", bif.req_ready, 1);
        frame(4'hF, 2, 3);
        // randomized traffic
        scr = 1;
        repeat (40) begin
            idle_cyc(4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0, acc);
            if (acc) frame(4'($urandom), $urandom_range(0, 4) == 0 ? 0 : $urandom_range(1, T), $urandom_range(1, 6));
        end
        idle_cyc(4'h0, 1'b0, acc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
